parser_conf_master: RTL and testbench

Rule-configuration initiator for `Parser_Top`. It accepts host commands (write or read, 32-bit address, 32-bit data) over a valid/ready stream and drives them onto the parser's rule port (`i_rule_wren`/`i_rule_rden`/`i_rule_addr`/`i_rule_wdata`). For reads it waits for `o_rule_rdata_valid`/`o_rule_rdata`, and it returns exactly one response per command. It sits between the control-plane bus bridge and `Parser_Top`, replacing hierarchical `force` configuration.

---
 rtl/parser_pkg.sv | 14 +
 rtl/parser_conf_timer.sv | 15 +
 rtl/parser_conf_master.sv | 118 +++++++++++
 tb/tb_parser_conf_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// parser_pkg: shared types and region codes for the parser rule-configuration path.
package parser_pkg;
    typedef enum logic {CONF_WR, CONF_RD} conf_op_e;
    typedef enum logic [1:0] {CONF_OK, CONF_BAD_REGION, CONF_TIMEOUT} conf_err_e;
    localparam logic [2:0] REG_RULE       = 3'd0;
    localparam logic [2:0] REG_TYPE       = 3'd1;
    localparam logic [2:0] REG_TYPE_OFS   = 3'd2;
    localparam logic [2:0] REG_KEY_OFS    = 3'd3;
    localparam logic [2:0] REG_HEAD_SHIFT = 3'd4;
    localparam logic [2:0] REG_META_SHIFT = 3'd5;
    function automatic logic region_bad(input logic [2:0] region, input int max);
        return int'({29'd0, region}) > max;
    endfunction
endpackage

// File: rtl/parser_conf_timer.sv
// parser_conf_timer: read-response timeout; expires so the response lands TIMEOUT_CYC cycles after RD_WAIT entry.
module parser_conf_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_expire
);
    logic [15:0] cnt_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt_q <= '0;
        else cnt_q <= i_run ? cnt_q + 16'd1 : 16'd0;
    assign o_expire = i_run && cnt_q == 16'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/parser_conf_master.sv
// parser_conf_master: host command -> parser rule-port initiator, one response per command.
// Optional read timeout enabled by defining PARSER_CONF_TIMEOUT_EN.
module parser_conf_master
    import parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int REGION_MAX  = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_op,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rule_wren,
    output logic        o_rule_rden,
    output logic [31:0] o_rule_addr,
    output logic [31:0] o_rule_wdata,
    input  logic        i_rule_rdata_valid,
    input  logic [31:0] i_rule_rdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic [1:0]  o_resp_err,
    output logic [7:0]  o_late_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_e;
    state_e      state_q;
    conf_op_e    op_q;
    conf_err_e   resp_err_q;
    logic        cmd_ready_q, wren_q, rden_q, resp_valid_q;
    logic [31:0] addr_q, wdata_q, resp_rdata_q;
    logic [7:0]  late_q;
    logic        accept, timeout;
    assign accept = i_cmd_valid && cmd_ready_q;
`ifdef PARSER_CONF_TIMEOUT_EN
    parser_conf_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (state_q == RD_WAIT),
        .o_expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            op_q         <= CONF_WR;
            cmd_ready_q  <= 1'b0;
            wren_q       <= 1'b0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= CONF_OK;
            late_q       <= '0;
        end else begin
            // Parser data outside RD_WAIT has no command to belong to.
            if (i_rule_rdata_valid && state_q != RD_WAIT && late_q != 8'hFF)
                late_q <= late_q + 8'd1;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= !accept;
                    if (accept) begin
                        op_q    <= conf_op_e'(i_cmd_op);
                        addr_q  <= i_cmd_addr;
                        wdata_q <= i_cmd_wdata;
                        if (region_bad(i_cmd_addr[10:8], REGION_MAX)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= CONF_BAD_REGION;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= ISSUE;
                            wren_q  <= !i_cmd_op;
                            rden_q  <= i_cmd_op;
                        end
                    end
                end
                ISSUE: begin
                    wren_q <= 1'b0;
                    rden_q <= 1'b0;
                    if (op_q == CONF_RD) state_q <= RD_WAIT;
                    else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= CONF_OK;
                        resp_rdata_q <= '0;
                    end
                end
                RD_WAIT: if (i_rule_rdata_valid || timeout) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= i_rule_rdata_valid ? CONF_OK : CONF_TIMEOUT;
                    resp_rdata_q <= i_rule_rdata_valid ? i_rule_rdata : 32'd0;
                end
                RESP: if (i_resp_ready) begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_cmd_ready  = cmd_ready_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_rden  = rden_q;
    assign o_rule_addr  = addr_q;
    assign o_rule_wdata = wdata_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_rdata = resp_rdata_q;
    assign o_resp_err   = resp_err_q;
    assign o_late_cnt   = late_q;
endmodule

// File: tb/tb_parser_conf_master.sv
// tb_parser_conf_master: randomized and directed checks of parser_conf_master against a cycle-count model.
module tb_parser_conf_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0, rdv = 1'b0, resp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, rdata = '0;
    logic        cmd_ready, rule_wren, rule_rden, resp_valid;
    logic [31:0] rule_addr, rule_wdata, resp_rdata;
    logic [1:0]  resp_err;
    logic [7:0]  late_cnt;
    int n_checks = 0, n_fail = 0, exp_late = 0;
    logic [31:0] d_addr [5] = '{32'h0000_0104, 32'h0000_0300, 32'h0000_0600, 32'h0000_0500, 32'h0000_0700};
    logic [31:0] d_wd   [5] = '{32'h00FF_0008, 32'h0, 32'h0000_1234, 32'h0000_CAFE, 32'h0};
    logic [31:0] d_pd   [5] = '{32'h0, 32'h0001_000C, 32'h0, 32'h0, 32'h0};
    logic        d_op   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          d_k    [5] = '{1, 3, 1, 1, 1};

    parser_conf_master dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rule_wren(rule_wren), .o_rule_rden(rule_rden), .o_rule_addr(rule_addr),
        .o_rule_wdata(rule_wdata), .i_rule_rdata_valid(rdv), .i_rule_rdata(rdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata),
        .o_resp_err(resp_err), .o_late_cnt(late_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step;
        step;
        n_checks++;
        if ({cmd_ready, rule_wren, rule_rden, resp_valid, rule_addr, rule_wdata, resp_rdata, resp_err, late_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b wren=%b rden=%b rv=%b late=%0d expected all zero", cmd_ready, rule_wren, rule_rden, resp_valid, late_cnt);
        end
        rst = 1'b0;
        step;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_transactions(input int n);
        logic op, bad, s_ok;
        logic [31:0] addr, wd, pd, exp_rd;
        int k, exp_lat, c, w, wr_n, rd_n;
        for (int i = 0; i < n; i++) begin
            if (i < 5) begin
                op = d_op[i]; addr = d_addr[i]; wd = d_wd[i]; k = d_k[i]; pd = d_pd[i];
            end else begin
                op = 1'($urandom_range(0, 1)); addr = $urandom; addr[10:8] = 3'($urandom_range(0, 7));
                wd = $urandom; k = $urandom_range(1, 5); pd = $urandom;
            end
            bad = addr[10:8] > 3'd5;
            exp_lat = bad ? 1 : (op ? 2 + k : 2);
            exp_rd = (op && !bad) ? pd : 32'd0;
            w = 0;
            while (!cmd_ready && w < 20) begin step; w++; end
            cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
            step;
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
            c = 1; wr_n = 0; rd_n = 0; s_ok = 1'b1;
            while (1) begin
                if (rule_wren) begin wr_n++; if (c != 1 || rule_addr !== addr || rule_wdata !== wd) s_ok = 1'b0; end
                if (rule_rden) begin rd_n++; if (c != 1 || rule_addr !== addr) s_ok = 1'b0; end
                if (resp_valid || c > 60) break;
                rdv = op && !bad && c == 1 + k;
                rdata = rdv ? pd : $urandom;
                step;
                c++;
            end
            rdv = 1'b0;
            n_checks++;
            if (c !== exp_lat) begin n_fail++; $display("FAIL txn%0d_latency: got %0d expected %0d", i, c, exp_lat); end
            n_checks++;
            if (wr_n !== int'(!bad && !op) || rd_n !== int'(!bad && op) || !s_ok) begin
                n_fail++; $display("FAIL txn%0d_strobes: got wr=%0d rd=%0d ok=%b expected wr=%0d rd=%0d ok=1", i, wr_n, rd_n, s_ok, int'(!bad && !op), int'(!bad && op));
            end
            n_checks++;
            if (resp_err !== {1'b0, bad} || resp_rdata !== exp_rd) begin
                n_fail++; $display("FAIL txn%0d_resp: got err=%0d rdata=%h expected err=%0d rdata=%h", i, resp_err, resp_rdata, bad, exp_rd);
            end
            n_checks++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL txn%0d_ready_in_resp: got %b expected 0", i, cmd_ready); end
            resp_ready = 1'b1;
            step;
            resp_ready = 1'b0;
            n_checks++;
            if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL txn%0d_handshake: got rv=%b ready=%b expected rv=0 ready=1", i, resp_valid, cmd_ready);
            end
        end
        n_checks++;
        if (late_cnt !== 8'(exp_late)) begin n_fail++; $display("FAIL txn_late_cnt: got %0d expected %0d", late_cnt, exp_late); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        int w;
        d = $urandom;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0100; cmd_wdata = '0;
        step;
        cmd_addr = 32'h0000_0004; cmd_op = 1'b0;
        step;
        rdv = 1'b1; rdata = d;
        step;
        rdv = 1'b0;
        w = 0;
        while (!resp_valid && w < 10) begin step; w++; end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== d || resp_err !== 2'd0 || cmd_ready !== 1'b0 || rule_wren || rule_rden) begin
                n_fail++; $display("FAIL backpressure_c%0d: got rv=%b rdata=%h err=%0d ready=%b wren=%b rden=%b expected rv=1 rdata=%h err=0 ready=0 no strobes",
                                   i, resp_valid, resp_rdata, resp_err, cmd_ready, rule_wren, rule_rden, d);
            end
            step;
        end
        cmd_valid = 1'b0; resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
    endtask

    task automatic test_late;
        logic [31:0] d;
        d = $urandom;
        for (int i = 0; i < 3; i++) begin rdv = 1'b1; step; rdv = 1'b0; step; exp_late++; end
        n_checks++;
        if (late_cnt !== 8'(exp_late)) begin n_fail++; $display("FAIL late_idle: got %0d expected %0d", late_cnt, exp_late); end
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0200;
        step;
        cmd_valid = 1'b0;
        rdv = 1'b1; rdata = ~d;
        step;
        rdv = 1'b0; exp_late++;
        step;
        rdv = 1'b1; rdata = d;
        step;
        rdv = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== d || late_cnt !== 8'(exp_late)) begin
            n_fail++; $display("FAIL late_k0: got rv=%b rdata=%h late=%0d expected rv=1 rdata=%h late=%0d", resp_valid, resp_rdata, late_cnt, d, exp_late);
        end
        resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
        rdv = 1'b1;
        repeat (300) step;
        rdv = 1'b0;
        exp_late = 255;
        n_checks++;
        if (late_cnt !== 8'd255) begin n_fail++; $display("FAIL late_saturate: got %0d expected 255", late_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [6:1] wr_bits, rs_bits;
        resp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 32'h0000_0104; cmd_wdata = $urandom;
        step;
        for (int c = 1; c <= 6; c++) begin
            wr_bits[c] = rule_wren;
            rs_bits[c] = resp_valid;
            if (c == 4) cmd_valid = 1'b0;
            step;
        end
        resp_ready = 1'b0;
        n_checks++;
        if (wr_bits !== 6'b001001 || rs_bits !== 6'b010010) begin
            n_fail++; $display("FAIL back_to_back: got wren=%b resp=%b expected wren=001001 resp=010010", wr_bits, rs_bits);
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0000;
        step;
        cmd_valid = 1'b0;
        step;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, rule_wren, rule_rden, resp_valid, rule_addr, rule_wdata, resp_rdata, resp_err, late_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got ready=%b rv=%b late=%0d expected all zero", cmd_ready, resp_valid, late_cnt);
        end
        step;
        rst = 1'b0;
        exp_late = 0;
        step;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b expected 1", cmd_ready); end
        rdv = 1'b1;
        step;
        rdv = 1'b0;
        exp_late = 1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_resp_c%0d: got %b expected 0", i, resp_valid); end
            step;
        end
        n_checks++;
        if (late_cnt !== 8'(exp_late)) begin n_fail++; $display("FAIL reset_mid_late: got %0d expected %0d", late_cnt, exp_late); end
    endtask

`ifdef PARSER_CONF_TIMEOUT_EN
    task automatic test_timeout;
        int c;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0500;
        step;
        cmd_valid = 1'b0;
        c = 1;
        while (!resp_valid && c < 200) begin step; c++; end
        n_checks++;
        if (c !== 66 || resp_err !== 2'd2 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL timeout: got cycle=%0d err=%0d rdata=%h expected cycle=66 err=2 rdata=0", c, resp_err, resp_rdata);
        end
        rdv = 1'b1;
        step;
        rdv = 1'b0;
        exp_late++;
        n_checks++;
        if (late_cnt !== 8'(exp_late)) begin n_fail++; $display("FAIL timeout_late: got %0d expected %0d", late_cnt, exp_late); end
        resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_transactions(40);
        test_backpressure;
        test_late;
        test_back_to_back;
        test_reset_mid;
`ifdef PARSER_CONF_TIMEOUT_EN
        test_timeout;
`endif
        test_transactions(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
